pc_fetch_unit: RTL and testbench

//  Holds the program counter and fetches instructions over a variable-latency

---
 rtl/pc_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch over a variable-latency imem req/ack handshake.
// Optional misaligned-PC trap: define PC_ALIGN_TRAP_EN (default build forces alignment).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
`ifdef PC_ALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  localparam logic [1:0] NPC_PLUS4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH   = 2'b01;
  localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
  localparam logic [1:0] NPC_JUMP_REG = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_ISSUE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_commit;
  logic        w_load;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_misalign;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_npc_raw;
  logic [31:0] w_pc_next;
  logic        w_misalign;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign pc_plus4    = w_pc_plus4;
  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign imem_req    = r_req;
  assign instr_valid = r_valid;
  assign misalign    = r_misalign;

  // Next-state decode; instr is captured on ack in REQ, pc commits on an unstalled ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_ISSUE: begin
        if (stall) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_REQ;
          w_commit    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Raw next-PC select; all arithmetic wraps modulo 2^32.
  always_comb begin
    w_npc_raw = w_pc_plus4;
    case (npc_op)
      NPC_PLUS4:    w_npc_raw = w_pc_plus4;
      NPC_BRANCH:   w_npc_raw = w_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      NPC_JUMP_IMM: w_npc_raw = {w_pc_plus4[31:28], imm26, 2'b00};
      NPC_JUMP_REG: w_npc_raw = rs_data;
      default:      w_npc_raw = w_pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_TRAP_EN
  // A misaligned target redirects to the trap vector and flags the commit.
  always_comb begin
    w_misalign = 1'b0;
    w_pc_next  = w_npc_raw;
    if (w_npc_raw[1:0] != 2'b00) begin
      w_misalign = 1'b1;
      w_pc_next  = TRAP_VECTOR;
    end else begin
      w_misalign = 1'b0;
      w_pc_next  = w_npc_raw;
    end
  end
`else
  // Without the trap the low address bits are simply dropped.
  always_comb begin
    w_misalign = 1'b0;
    w_pc_next  = w_npc_raw & 32'hFFFF_FFFC;
  end
`endif

  // State, PC, instruction and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= (w_state_nxt == S_REQ);
      r_valid    <= (w_state_nxt == S_ISSUE);
      r_misalign <= w_commit & w_misalign;
      if (w_commit) begin
        r_pc <= w_pc_next;
      end else begin
        r_pc <= r_pc;
      end
      if (w_load) begin
        r_instr <= imem_rdata;
      end else begin
        r_instr <= r_instr;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: expected fetch PCs are queued when
// the next-PC stimulus is driven and compared when the DUT issues the instruction.
module tb_pc_fetch_unit;

  localparam logic [1:0] NPC_PLUS4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH   = 2'b01;
  localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
  localparam logic [1:0] NPC_JUMP_REG = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic [15:0] imm16 = 16'h0000;
  logic [25:0] imm26 = 26'h0;
  logic [31:0] rs_data = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .imm16(imm16), .imm26(imm26),
    .rs_data(rs_data), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, hold ack off for ack_delay cycles, ack, then check the issue.
  task automatic do_fetch(input int ack_delay, output int waits);
    logic [31:0] exp_pc;
    logic        found;
    exp_pc = exp_q.pop_front();
    found  = 1'b0;
    waits  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waits++;
      if (imem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk("req_seen", {31'd0, found}, 32'd1);
    chk("req_addr", imem_addr, exp_pc);
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_pc", pc, exp_pc);
    chk("issue_instr", instr, mem_word(exp_pc));
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("issue_req_low", {31'd0, imem_req}, 32'd0);
  endtask

  // Drive next-PC controls in ISSUE, optionally stalling, and queue the expected target.
  task automatic issue(input logic [1:0] op, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs, input int stall_n, input logic [31:0] exp_next);
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    hold_pc    = pc;
    hold_instr = instr;
    npc_op  = op;
    imm16   = i16;
    imm26   = i26;
    rs_data = rs;
    exp_q.push_back(exp_next);
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int s = 0; s < stall_n; s++) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_0000 + s;
        @(negedge clk);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("stall_pc", pc, hold_pc);
        chk("stall_instr", instr, hold_instr);
      end
      imem_ack = 1'b0;
      stall    = 1'b0;
    end
  endtask

  initial begin
    int w;
    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_pc", pc, 32'h0000_3000);

    // Sequential, zero-wait
    exp_q.push_back(32'h0000_3000);
    do_fetch(0, w);
    chk("first_req_latency", w, 32'd1);
    issue(NPC_PLUS4, 16'h0, 26'h0, 32'h0, 0, 32'h0000_3004);
    do_fetch(0, w);
    chk("two_cycle_rate", w, 32'd1);
    issue(NPC_PLUS4, 16'h0, 26'h0, 32'h0, 0, 32'h0000_3008);
    do_fetch(0, w);
    chk("two_cycle_rate2", w, 32'd1);

    // Branches
    issue(NPC_BRANCH, 16'hFFFF, 26'h0, 32'h0, 0, 32'h0000_3008);
    do_fetch(2, w);
    issue(NPC_BRANCH, 16'h0003, 26'h0, 32'h0, 0, 32'h0000_3018);
    do_fetch(0, w);

    // Jump-register with misaligned target, stalled 3 cycles with stray acks
    issue(NPC_JUMP_REG, 16'h0, 26'h0, 32'h0000_4001, 3, 32'h0000_4000);
    do_fetch(4, w);
    chk("no_misalign", {31'd0, misalign}, 32'd0);
    issue(NPC_JUMP_IMM, 16'h0, 26'h0C10, 32'h0, 0, 32'h0000_3040);
    do_fetch(1, w);

    // Wrap at the top of the address space
    issue(NPC_JUMP_REG, 16'h0, 26'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    do_fetch(0, w);
    issue(NPC_PLUS4, 16'h0, 26'h0, 32'h0, 0, 32'h0000_0000);
    do_fetch(0, w);

    // Reset in the middle of a fetch
    issue(NPC_PLUS4, 16'h0, 26'h0, 32'h0, 0, 32'h0000_0004);
    @(negedge clk);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req_low", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, 32'h0000_3000);
    exp_q.delete();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_ignored", instr, 32'h0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b0;
    exp_q.push_back(32'h0000_3000);
    do_fetch(0, w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
